// File: rtl/audio_fe_pkg.sv
// Shared definitions for the audio front-end: STFFT-compatible defaults,
// power-spectrum FSM states and counter/bin width helpers.
package audio_fe_pkg;

  localparam int unsigned DEF_IW       = 18;
  localparam int unsigned DEF_FFT_SIZE = 256;
  localparam int unsigned DEF_PW       = 24;
  localparam int unsigned DEF_SHIFT    = 8;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } fps_state_e;

  function automatic int unsigned cnt_width(input int unsigned fft_size);
    return $clog2(fft_size);
  endfunction

  // Bins 0..FFT_SIZE/2 inclusive.
  function automatic int unsigned bin_width(input int unsigned fft_size);
    return $clog2(fft_size / 2 + 1);
  endfunction

endpackage

// File: rtl/fft_power_spectrum_if.sv
// FFT-bin input stream and power-spectrum output stream of fft_power_spectrum.
interface fft_power_spectrum_if
  import audio_fe_pkg::*;
#(
  parameter int unsigned IW = DEF_IW,
  parameter int unsigned PW = DEF_PW,
  parameter int unsigned BW = bin_width(DEF_FFT_SIZE)
);

  logic            i_ce;
  logic [2*IW-1:0] i_fft_result;
  logic            i_fft_sync;
  logic            o_valid;
  logic [PW-1:0]   o_power;
  logic [BW-1:0]   o_bin;
  logic            o_last;
  logic            o_sat;
  logic            o_frame_err;

  modport slave (
    input  i_ce, i_fft_result, i_fft_sync,
    output o_valid, o_power, o_bin, o_last, o_sat, o_frame_err
  );

  modport master (
    output i_ce, i_fft_result, i_fft_sync,
    input  o_valid, o_power, o_bin, o_last, o_sat, o_frame_err
  );

endinterface

// File: rtl/cplx_mag_sq.sv
// Two-stage |X|^2 pipeline: S1 registers re^2 and im^2, S2 registers their sum.
// A valid bit and an opaque tag travel alongside each sample.
module cplx_mag_sq #(
  parameter int unsigned IW = 18,
  parameter int unsigned TW = 9
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic signed [IW-1:0] i_re,
  input  logic signed [IW-1:0] i_im,
  input  logic [TW-1:0]        i_tag,
  output logic                 o_valid,
  output logic [2*IW-1:0]      o_sum,
  output logic [TW-1:0]        o_tag
);

  logic signed [2*IW-1:0] re_x, im_x;
  logic [2*IW-1:0]        sq_re_q, sq_im_q;
  logic [TW-1:0]          tag1_q;
  logic                   valid1_q;

  // Squares are non-negative and below 2^(2*IW-1), so the sum cannot wrap.
  assign re_x = {{IW{i_re[IW-1]}}, i_re};
  assign im_x = {{IW{i_im[IW-1]}}, i_im};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      valid1_q <= 1'b0;
      sq_re_q  <= '0;
      sq_im_q  <= '0;
      tag1_q   <= '0;
      o_valid  <= 1'b0;
      o_sum    <= '0;
      o_tag    <= '0;
    end else begin
      valid1_q <= i_valid;
      sq_re_q  <= re_x * re_x;
      sq_im_q  <= im_x * im_x;
      tag1_q   <= i_tag;
      o_valid  <= valid1_q;
      o_sum    <= sq_re_q + sq_im_q;
      o_tag    <= tag1_q;
    end
  end

endmodule

// File: rtl/fft_power_spectrum.sv
// Streaming power spectrum of the non-redundant FFT bins 0..FFT_SIZE/2, with
// frame tracking from the FFT sync pulse and a 3-cycle scaled/saturated output.
module fft_power_spectrum
  import audio_fe_pkg::*;
#(
  parameter int unsigned IW       = DEF_IW,
  parameter int unsigned FFT_SIZE = DEF_FFT_SIZE,
  parameter int unsigned PW       = DEF_PW,
  parameter int unsigned SHIFT    = DEF_SHIFT
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  fft_power_spectrum_if.slave   bus
);

  localparam int unsigned CW = cnt_width(FFT_SIZE);
  localparam int unsigned BW = bin_width(FFT_SIZE);
  localparam int unsigned TW = BW + 1;
  localparam logic [CW-1:0]   HALF = CW'(FFT_SIZE / 2);
  localparam logic [2*IW-1:0] PMAX = {{(2*IW-PW){1'b0}}, {PW{1'b1}}};

  fps_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, bin_idx;
  logic           take, keep, err, frame_err_q;
  logic [TW-1:0]  tag_in, tag_s2;
  logic           valid_s2;
  logic [2*IW-1:0] sum_s2, shifted;
  logic           clip;

  logic           valid_q, last_q, sat_q;
  logic [PW-1:0]  power_q;
  logic [BW-1:0]  bin_q;

  // A sync always restarts the frame at bin 0, whatever the counter says.
  assign bin_idx = bus.i_fft_sync ? '0 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    err     = 1'b0;
    if (bus.i_ce) begin
      case (state_q)
        WAIT_SYNC: if (bus.i_fft_sync) begin
          take    = 1'b1;
          state_d = RUN;
          cnt_d   = bin_idx + CW'(1);
        end
        RUN: if (bus.i_fft_sync) begin
          take  = 1'b1;
          err   = (cnt_q != '0);
          cnt_d = bin_idx + CW'(1);
        end else if (cnt_q == '0) begin
          err     = 1'b1;
          state_d = WAIT_SYNC;
        end else begin
          take  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  assign keep   = take && (bin_idx <= HALF);
  assign tag_in = {bin_idx == HALF, bin_idx[BW-1:0]};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= WAIT_SYNC;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= err;
    end
  end

  cplx_mag_sq #(.IW(IW), .TW(TW)) u_mag (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (keep),
    .i_re      (bus.i_fft_result[2*IW-1:IW]),
    .i_im      (bus.i_fft_result[IW-1:0]),
    .i_tag     (tag_in),
    .o_valid   (valid_s2),
    .o_sum     (sum_s2),
    .o_tag     (tag_s2)
  );

  assign shifted = sum_s2 >> SHIFT;
  assign clip    = shifted > PMAX;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
      power_q <= '0;
      bin_q   <= '0;
    end else begin
      valid_q <= valid_s2;
      last_q  <= valid_s2 && tag_s2[BW];
      sat_q   <= valid_s2 && clip;
      if (valid_s2) begin
        power_q <= clip ? '1 : shifted[PW-1:0];
        bin_q   <= tag_s2[BW-1:0];
      end
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_power     = power_q;
  assign bus.o_bin       = bin_q;
  assign bus.o_last      = last_q;
  assign bus.o_sat       = sat_q;
  assign bus.o_frame_err = frame_err_q;

endmodule
